// File: rtl/flash_read_ctrl_if.sv
// Wishbone slave bundle between the management SoC and the flash read sequencer.
interface flash_read_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/flash_read_ctrl.sv
// Timed sense/output-enable sequencer for the 8x8 flash array with a
// four-word Wishbone register file (CTRL, STATUS, DATA, reserved).
module flash_read_ctrl #(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int unsigned SEN1_CYC   = 4,
  parameter int unsigned SEN2_CYC   = 4,
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  flash_read_ctrl_if.slave wb,
  output logic             sen1,
  output logic             sen2,
  output logic [3:0]       out_en,
  input  logic [7:0]       array_out,
  output logic             irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEN1, ST_SEN2, ST_EN} state_e;

  localparam logic [7:0] SEN1_LD   = 8'(SEN1_CYC - 1);
  localparam logic [7:0] SEN2_LD   = 8'(SEN2_CYC - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  ctrl_sel_q, ctrl_sel_d;
  logic        irq_en_q, irq_en_d;
  logic [3:0]  sel_lat_q, sel_lat_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  sync1_q, sync2_q;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        sen1_q, sen1_d;
  logic        sen2_q, sen2_d;
  logic [3:0]  out_en_q, out_en_d;
  logic        irq_q, irq_d;

  logic        hit, wr, start_wr, status_wr, capture;
  logic [1:0]  reg_idx;
  logic [31:0] rdata;
  logic        unused_bits;

  // A new access is refused on the cycle after an ack, so held strobes get 2-cycle spacing.
  assign hit       = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q
                   & (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign wr        = hit & wb.wbs_we_i;
  assign reg_idx   = wb.wbs_adr_i[3:2];
  assign start_wr  = wr & (reg_idx == 2'd0) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
  assign status_wr = wr & (reg_idx == 2'd1) & wb.wbs_sel_i[0];

  assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:2],
                         wb.wbs_dat_i[31:9], wb.wbs_dat_i[3]};

  always_comb begin
    rdata = '0;
    unique case (reg_idx)
      2'd0: rdata = {23'd0, irq_en_q, ctrl_sel_q, 4'd0};
      2'd1: rdata = {29'd0, err_q, done_q, (state_q != ST_IDLE)};
      2'd2: rdata = {16'd0, count_q, data_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_sel_d = ctrl_sel_q;
    irq_en_d   = irq_en_q;
    sel_lat_d  = sel_lat_q;
    done_d     = done_q;
    err_d      = err_q;
    data_d     = data_q;
    count_d    = count_q;
    capture    = 1'b0;

    if (wr && reg_idx == 2'd0) begin
      if (wb.wbs_sel_i[0]) ctrl_sel_d = wb.wbs_dat_i[7:4];
      if (wb.wbs_sel_i[1]) irq_en_d   = wb.wbs_dat_i[8];
    end
    if (status_wr) begin
      if (wb.wbs_dat_i[1]) done_d = 1'b0;
      if (wb.wbs_dat_i[2]) err_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: if (start_wr) begin
        state_d   = ST_SEN1;
        cnt_d     = SEN1_LD;
        sel_lat_d = wb.wbs_dat_i[7:4];
      end
      ST_SEN1: if (cnt_q == 8'd0) begin
        state_d = ST_SEN2;
        cnt_d   = SEN2_LD;
      end else cnt_d = cnt_q - 8'd1;
      ST_SEN2: if (cnt_q == 8'd0) begin
        state_d = ST_EN;
        cnt_d   = SETTLE_LD;
      end else cnt_d = cnt_q - 8'd1;
      ST_EN: if (cnt_q == 8'd0) begin
        state_d = ST_IDLE;
        capture = 1'b1;
      end else cnt_d = cnt_q - 8'd1;
      default: state_d = ST_IDLE;
    endcase

    if (start_wr && state_q != ST_IDLE) err_d = 1'b1;

    // Completion is applied after the W1C clear so a coincident set wins.
    if (capture) begin
      data_d  = sync2_q;
      count_d = count_q + 8'd1;
      done_d  = 1'b1;
    end

    sen1_d   = (state_d != ST_IDLE);
    sen2_d   = (state_d == ST_SEN2) || (state_d == ST_EN);
    out_en_d = (state_d == ST_EN) ? sel_lat_d : 4'd0;
    irq_d    = done_q & irq_en_q;
    ack_d    = hit;
    dat_d    = hit ? rdata : 32'd0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ctrl_sel_q <= '0;
      irq_en_q   <= 1'b0;
      sel_lat_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      count_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      sen1_q     <= 1'b0;
      sen2_q     <= 1'b0;
      out_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_sel_q <= ctrl_sel_d;
      irq_en_q   <= irq_en_d;
      sel_lat_q  <= sel_lat_d;
      done_q     <= done_d;
      err_q      <= err_d;
      data_q     <= data_d;
      count_q    <= count_d;
      sync1_q    <= array_out;
      sync2_q    <= sync1_q;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      sen1_q     <= sen1_d;
      sen2_q     <= sen2_d;
      out_en_q   <= out_en_d;
      irq_q      <= irq_d;
    end
  end

  // Array controls come straight from flops so the macro never sees decode glitches.
  assign sen1         = sen1_q;
  assign sen2         = sen2_q;
  assign out_en       = out_en_q;
  assign irq          = irq_q;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Directed bench for flash_read_ctrl: a timeline model checked every cycle
// plus literal expectations for the key timing and register values.
module tb_flash_read_ctrl;
  localparam int SEN1   = 4;
  localparam int SEN2   = 4;
  localparam int SETTLE = 3;
  localparam int TOTAL  = SEN1 + SEN2 + SETTLE;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sen1, sen2, irq;
  logic [3:0] out_en;
  logic [7:0] array_out = 8'hA5;

  flash_read_ctrl_if wb ();

  flash_read_ctrl #(
    .BASE_ADR(BASE), .SEN1_CYC(SEN1), .SEN2_CYC(SEN2), .SETTLE_CYC(SETTLE)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (wb),
    .sen1     (sen1),
    .sen2     (sen2),
    .out_en   (out_en),
    .array_out(array_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: timeline of the last accepted START ----------------
  int         edge_n = 0;
  int         m_e0 = -1000;
  bit         m_busy, m_ack, m_irq, m_done, m_err, m_irq_en;
  logic [3:0] m_sel, m_sel_lat;
  logic [7:0] m_data, m_count, hist1, hist2;
  logic [31:0] m_dat;

  task automatic model_step();
    bit          acc, cap;
    logic [31:0] rd;
    logic [7:0]  synced;
    edge_n++;
    if (rst) begin
      m_busy = 0; m_ack = 0; m_irq = 0; m_done = 0; m_err = 0; m_irq_en = 0;
      m_sel = 0; m_sel_lat = 0; m_data = 0; m_count = 0; m_dat = 0;
      hist1 = 0; hist2 = 0;
      return;
    end
    synced = hist2;            // array_out as sampled two edges ago
    hist2  = hist1;
    hist1  = array_out;
    cap = m_busy && (edge_n == m_e0 + TOTAL);
    acc = wb.wbs_stb_i && wb.wbs_cyc_i && !m_ack && (wb.wbs_adr_i[31:4] == BASE[31:4]);
    case (wb.wbs_adr_i[3:2])
      2'd0:    rd = {23'd0, m_irq_en, m_sel, 4'd0};
      2'd1:    rd = {29'd0, m_err, m_done, m_busy};
      2'd2:    rd = {16'd0, m_count, m_data};
      default: rd = 32'd0;
    endcase
    m_irq = m_done && m_irq_en;
    m_ack = acc;
    m_dat = acc ? rd : 32'd0;
    if (acc && wb.wbs_we_i) begin
      if (wb.wbs_adr_i[3:2] == 2'd0) begin
        if (wb.wbs_sel_i[0]) m_sel = wb.wbs_dat_i[7:4];
        if (wb.wbs_sel_i[1]) m_irq_en = wb.wbs_dat_i[8];
        if (wb.wbs_sel_i[0] && wb.wbs_dat_i[0]) begin
          if (m_busy) m_err = 1;
          else begin
            m_busy = 1; m_e0 = edge_n; m_sel_lat = wb.wbs_dat_i[7:4];
          end
        end
      end else if (wb.wbs_adr_i[3:2] == 2'd1 && wb.wbs_sel_i[0]) begin
        if (wb.wbs_dat_i[1]) m_done = 0;
        if (wb.wbs_dat_i[2]) m_err = 0;
      end
    end
    if (cap) begin
      m_busy = 0; m_data = synced; m_count = m_count + 8'd1; m_done = 1;
    end
  endtask

  // ---------------- per-cycle compare plus edge timestamps ----------------
  int         sen1_rise, sen1_fall, sen2_rise, out_en_rise, irq_rise;
  logic [3:0] out_en_seen;
  logic       p_sen1 = 0, p_sen2 = 0, p_irq = 0;
  logic [3:0] p_out_en = 0;

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      begin
        int ph;
        ph = edge_n - m_e0;
        check("sen1",   sen1,   m_busy);
        check("sen2",   sen2,   m_busy && ph >= SEN1);
        check("out_en", out_en, (m_busy && ph >= SEN1 + SEN2) ? m_sel_lat : 4'd0);
        check("irq",    irq,    m_irq);
        check("ack",    wb.wbs_ack_o, m_ack);
        check("dat",    wb.wbs_dat_o, m_dat);
      end
      if (sen1 && !p_sen1) sen1_rise = edge_n;
      if (!sen1 && p_sen1) sen1_fall = edge_n;
      if (sen2 && !p_sen2) sen2_rise = edge_n;
      if (out_en != 0 && p_out_en == 0) begin out_en_rise = edge_n; out_en_seen = out_en; end
      if (irq && !p_irq) irq_rise = edge_n;
      p_sen1 = sen1; p_sen2 = sen2; p_out_en = out_en; p_irq = irq;
    end
  end

  // ---------------- Wishbone driver ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
    @(negedge clk);
    wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr; wb.wbs_dat_i = dat; wb.wbs_sel_i = sel;
    acked = 0; rdat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) begin acked = 1; rdat = wb.wbs_dat_o; break; end
    end
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    logic        a;
    wb_xfer(1'b1, adr, dat, sel, r, a);
    check("wr_ack", a, 1'b1);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] r);
    logic a;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, r, a);
    check("rd_ack", a, 1'b1);
  endtask

  localparam logic [31:0] CTRL = BASE + 32'h0, STAT = BASE + 32'h4, DATA = BASE + 32'h8;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        a;
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", wb.wbs_ack_o, 0);
    check("rst_dat", wb.wbs_dat_o, 0);
    check("rst_ctl", {sen1, sen2, out_en, irq}, 0);
    rst = 0;
    wb_read(STAT, r); check("rst_status", r, 32'h0);
    wb_read(DATA, r); check("rst_data",   r, 32'h0);
    wb_read(CTRL, r); check("rst_ctrl",   r, 32'h0);

    // Basic read sequence with timing pins
    array_out = 8'h3C;
    wb_write(CTRL, 32'h0000_0151, 4'hF);
    repeat (14) @(negedge clk);
    check("t_sen1_rise", sen1_rise - m_e0, 0);
    check("t_sen2_rise", sen2_rise - m_e0, 4);
    check("t_oen_rise",  out_en_rise - m_e0, 8);
    check("oen_value",   out_en_seen, 4'h5);
    check("t_done",      sen1_fall - m_e0, 11);
    check("t_irq",       irq_rise - m_e0, 12);
    wb_read(DATA, r); check("data_1", r, 32'h0000_013C);
    wb_read(STAT, r); check("stat_done", r, 32'h2);

    // W1C clears DONE and irq; W1C coincident with completion keeps DONE
    wb_write(STAT, 32'h2, 4'h1);
    wb_read(STAT, r); check("stat_w1c", r, 32'h0);
    check("irq_cleared", irq, 0);
    wb_write(CTRL, 32'h0000_0151, 4'hF);
    repeat (9) @(negedge clk);
    wb_write(STAT, 32'h2, 4'h1);
    check("t_w1c_race", edge_n - m_e0, 11);
    wb_read(STAT, r); check("stat_set_wins", r, 32'h2);

    // START while busy
    wb_write(STAT, 32'h6, 4'h1);
    wb_write(CTRL, 32'h0000_0151, 4'hF);
    repeat (3) @(negedge clk);
    wb_write(CTRL, 32'h0000_00A1, 4'hF);
    repeat (10) @(negedge clk);
    check("busy_oen",    out_en_seen, 4'h5);
    check("busy_t_done", sen1_fall - m_e0, 11);
    wb_read(STAT, r); check("stat_err", r, 32'h6);
    wb_read(DATA, r); check("data_cnt3", r, 32'h0000_033C);
    wb_read(CTRL, r); check("ctrl_sel_a", r, 32'h0000_00A0);

    // Reset during SEN2
    wb_write(CTRL, 32'h0000_0151, 4'hF);
    repeat (5) @(negedge clk);
    check("pre_rst_sen2", sen2, 1);
    #2 rst = 1;
    #1;
    check("async_sen1", sen1, 0);
    check("async_sen2", sen2, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    wb_read(STAT, r); check("post_rst_stat", r, 32'h0);
    wb_read(DATA, r); check("post_rst_data", r, 32'h0);

    // Count wrap over 256 back-to-back reads
    for (int i = 0; i < 256; i++) begin
      array_out = 8'(i * 7);
      wb_write(CTRL, 32'h0000_0031, 4'hF);
      repeat (10) @(negedge clk);
      if (i == 254) begin
        wb_read(DATA, r); check("data_cnt_ff", r, 32'h0000_FFF2);
      end
    end
    wb_read(DATA, r); check("data_wrap", r, 32'h0000_00F9);
    wb_read(STAT, r); check("wrap_stat", r, 32'h2);

    // Reserved register and out-of-base address
    wb_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'hC, r); check("rsvd_read", r, 32'h0);
    wb_xfer(1'b1, BASE + 32'h10, 32'h1, 4'hF, r, a); check("oob_wr_ack", a, 0);
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, r, a); check("oob_rd_ack", a, 0);
    check("oob_no_start", sen1, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
